// File: rtl/snes_pad_device_pkg.sv
// Shared definitions for the SNES pad device and reader: FSM state type,
// default frame width and button bit positions (bit 15 is shifted out first).
package snes_pad_device_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } snes_state_e;

    localparam int unsigned REG_SIZE_DEF = 16;

    localparam int unsigned BTN_B      = 15;
    localparam int unsigned BTN_Y      = 14;
    localparam int unsigned BTN_SELECT = 13;
    localparam int unsigned BTN_START  = 12;
    localparam int unsigned BTN_UP     = 11;
    localparam int unsigned BTN_DOWN   = 10;
    localparam int unsigned BTN_LEFT   = 9;
    localparam int unsigned BTN_RIGHT  = 8;
    localparam int unsigned BTN_A      = 7;
    localparam int unsigned BTN_X      = 6;
    localparam int unsigned BTN_L      = 5;
    localparam int unsigned BTN_R      = 4;

endpackage

// File: rtl/snes_pad_device_sync_edge.sv
// snes_sync_edge: 2-FF synchronizer for an asynchronous pin, with a registered
// copy of the synchronized level for rising-edge detection.
module snes_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    // Synchronizer chain plus delayed copy for the edge detector.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= async_i;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign level_o = r_s2;
    assign rise_o  = r_s2 & ~r_prev;

endmodule

// File: rtl/snes_pad_device.sv
// snes_pad_device: virtual SNES pad (4021-style PISO shift register).
// Optional frame-abort timeout enabled by defining SNESDEV_TIMEOUT_EN.
module snes_pad_device
    import snes_pad_device_pkg::*;
#(
    parameter int unsigned REG_SIZE       = REG_SIZE_DEF,
    parameter logic        FILL_BIT       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 25_000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dlatch_i,
    input  logic                dclock_i,
    output logic                sdata_o,
    input  logic [REG_SIZE-1:0] buttons_i,
    output logic                frame_done_o,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int unsigned   CW      = $clog2(REG_SIZE);
    localparam logic [CW-1:0] LAST_M1 = CW'(REG_SIZE - 2);

    snes_state_e         r_state;
    snes_state_e         w_state_n;
    logic [REG_SIZE-1:0] r_shreg;
    logic [REG_SIZE-1:0] w_shreg_n;
    logic [CW-1:0]       r_bitcnt;
    logic [CW-1:0]       w_bitcnt_n;
    logic                r_sdata;
    logic                w_sdata_n;
    logic                r_done;
    logic                w_done_n;

    logic w_latch_s;
    logic w_latch_rise_unused;
    logic w_dclk_level_unused;
    logic w_dclk_rise;

    snes_sync_edge u_sync_latch (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (dlatch_i),
        .level_o (w_latch_s),
        .rise_o  (w_latch_rise_unused)
    );

    snes_sync_edge u_sync_dclk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (dclock_i),
        .level_o (w_dclk_level_unused),
        .rise_o  (w_dclk_rise)
    );

`ifdef SNESDEV_TIMEOUT_EN
    localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_tmo_cnt;
    logic [TW-1:0] w_tmo_cnt_n;
    logic          r_timeout;
    logic          w_timeout_n;

    // Idle-dclock counter: only runs in S_SHIFT, restarts on every dclock edge.
    always_comb begin
        w_tmo_cnt_n = r_tmo_cnt;
        if (r_state != S_SHIFT || w_dclk_rise)
            w_tmo_cnt_n = '0;
        else if (r_tmo_cnt != TMO_LIMIT)
            w_tmo_cnt_n = r_tmo_cnt + TW'(1);
    end

    // Timeout counter and pulse register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_n;
            r_timeout <= w_timeout_n;
        end
    end

    assign timeout_o = r_timeout;
`else
    localparam int unsigned TMO_CFG_unused = TIMEOUT_CYCLES;
    assign timeout_o = 1'b0;
`endif

    // Next-state, shift register and output decode; latch overrides everything.
    always_comb begin
        w_state_n  = r_state;
        w_shreg_n  = r_shreg;
        w_bitcnt_n = r_bitcnt;
        w_sdata_n  = r_sdata;
        w_done_n   = 1'b0;
`ifdef SNESDEV_TIMEOUT_EN
        w_timeout_n = 1'b0;
`endif
        if (w_latch_s) begin
            w_state_n  = S_LOAD;
            w_shreg_n  = buttons_i;
            w_bitcnt_n = '0;
            w_sdata_n  = buttons_i[REG_SIZE-1];
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sdata_n = FILL_BIT;
                end
                S_LOAD: begin
                    w_state_n = S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_dclk_rise) begin
                        w_shreg_n  = {r_shreg[REG_SIZE-2:0], FILL_BIT};
                        w_sdata_n  = r_shreg[REG_SIZE-2];
                        w_bitcnt_n = r_bitcnt + CW'(1);
                        if (r_bitcnt == LAST_M1) begin
                            w_done_n  = 1'b1;
                            w_state_n = S_DONE;
                        end
                    end
`ifdef SNESDEV_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LIMIT) begin
                        w_state_n   = S_IDLE;
                        w_sdata_n   = FILL_BIT;
                        w_timeout_n = 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    // Last bit stays on the line until the host clocks past it.
                    if (w_dclk_rise) begin
                        w_shreg_n = {r_shreg[REG_SIZE-2:0], FILL_BIT};
                        w_sdata_n = FILL_BIT;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end
    end

    // State, shift register, bit counter and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_shreg  <= {REG_SIZE{FILL_BIT}};
            r_bitcnt <= '0;
            r_sdata  <= FILL_BIT;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_shreg  <= w_shreg_n;
            r_bitcnt <= w_bitcnt_n;
            r_sdata  <= w_sdata_n;
            r_done   <= w_done_n;
        end
    end

    assign sdata_o      = r_sdata;
    assign frame_done_o = r_done;
    assign busy_o       = (r_state == S_LOAD) || (r_state == S_SHIFT);

endmodule

// File: tb/tb_snes_pad_device.sv
// Self-checking bench for snes_pad_device acting as a host: latches, clocks
// out frames and compares each serial bit against a scoreboard queue.
module tb_snes_pad_device;

    localparam logic FB = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dlatch = 1'b0;
    logic        dclock = 1'b0;
    logic [15:0] buttons = 16'h0000;
    logic        sdata;
    logic        frame_done;
    logic        busy;
    logic        timeout;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int tmo_cnt = 0;
    logic exp_q[$];

    typedef struct {
        string       name;
        logic [15:0] btn;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[6];

    snes_pad_device #(
        .REG_SIZE       (16),
        .FILL_BIT       (FB),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .dlatch_i     (dlatch),
        .dclock_i     (dclock),
        .sdata_o      (sdata),
        .buttons_i    (buttons),
        .frame_done_o (frame_done),
        .busy_o       (busy),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (timeout) tmo_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_check(input string name);
        logic e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %b expected a queued bit", name, sdata);
        end else begin
            e = exp_q.pop_front();
            check(name, {31'd0, sdata}, {31'd0, e});
        end
    endtask

    task automatic latch_on(input logic [15:0] b);
        buttons = b;
        dlatch  = 1'b1;
        cyc(6);
    endtask

    task automatic latch_off;
        dlatch = 1'b0;
        cyc(6);
    endtask

    task automatic dclk_pulse;
        dclock = 1'b1;
        cyc(5);
        dclock = 1'b0;
        cyc(5);
    endtask

    // Capture a frame MSB-first; sdata must already show bit 15.
    task automatic expect_frame(input string name, input logic [15:0] b, output logic [15:0] v);
        v = 16'h0000;
        for (int i = 15; i >= 0; i--) exp_q.push_back(b[i]);
        pop_check({name, "_b15"});
        v = {v[14:0], sdata};
        for (int i = 14; i >= 0; i--) begin
            dclk_pulse();
            pop_check($sformatf("%s_b%0d", name, i));
            v = {v[14:0], sdata};
        end
    endtask

    task automatic run_frame(input string name, input logic [15:0] b, input logic [15:0] exp_v);
        logic [15:0] v;
        int d0;
        latch_on(b);
        check({name, "_busy_load"}, {31'd0, busy}, 32'd1);
        latch_off();
        d0 = done_cnt;
        expect_frame(name, b, v);
        check({name, "_done_once"}, done_cnt - d0, 32'd1);
        check({name, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({name, "_vdata"}, {16'd0, v}, {16'd0, exp_v});
        exp_q.push_back(FB);
        exp_q.push_back(FB);
        dclk_pulse();
        pop_check({name, "_fill16"});
        dclk_pulse();
        pop_check({name, "_fill17"});
    endtask

    initial begin
        logic [15:0] v;
        int d0;
        int t0;

        tbl[0] = '{"a5c3", 16'hA5C3, 16'hA5C3};
        tbl[1] = '{"8001", 16'h8001, 16'h8001};
        tbl[2] = '{"0000", 16'h0000, 16'h0000};
        tbl[3] = '{"ffff", 16'hFFFF, 16'hFFFF};
        tbl[4] = '{"1234", 16'h1234, 16'h1234};
        tbl[5] = '{"7ffe", 16'h7FFE, 16'h7FFE};

        // Reset state
        cyc(3);
        check("rst_sdata", {31'd0, sdata}, {31'd0, FB});
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b0;
        cyc(3);
        check("idle_sdata", {31'd0, sdata}, {31'd0, FB});

        // Table-driven full frames
        for (int i = 0; i < 6; i++) run_frame(tbl[i].name, tbl[i].btn, tbl[i].exp);

        // Buttons change just after latch falls: frame keeps the latched value
        buttons = 16'h0000;
        dlatch  = 1'b1;
        cyc(6);
        dlatch = 1'b0;
        cyc(3);
        buttons = 16'hFFFF;
        cyc(3);
        expect_frame("late", 16'h0000, v);
        check("late_vdata", {16'd0, v}, 32'd0);
        dclk_pulse();

        // Restart after 5 edges: new MSB, full new frame, one done pulse only
        latch_on(16'h1234);
        latch_off();
        repeat (5) dclk_pulse();
        d0 = done_cnt;
        latch_on(16'hC003);
        exp_q.push_back(1'b1);
        pop_check("restart_msb");
        latch_off();
        expect_frame("restart", 16'hC003, v);
        check("restart_vdata", {16'd0, v}, {16'd0, 16'hC003});
        check("restart_done_once", done_cnt - d0, 32'd1);

        // Latch and dclock rise together mid-shift: load wins, no shift
        latch_on(16'h4002);
        latch_off();
        repeat (3) dclk_pulse();
        buttons = 16'h9009;
        dlatch  = 1'b1;
        dclock  = 1'b1;
        cyc(6);
        dlatch = 1'b0;
        cyc(6);
        dclock = 1'b0;
        cyc(5);
        expect_frame("simul", 16'h9009, v);
        check("simul_vdata", {16'd0, v}, {16'd0, 16'h9009});

        // Asynchronous reset mid-shift at bit 7
        latch_on(16'h3C5A);
        latch_off();
        repeat (7) dclk_pulse();
        d0 = done_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_sdata", {31'd0, sdata}, {31'd0, FB});
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        check("arst_no_done", done_cnt - d0, 32'd0);
        run_frame("post_rst", 16'h3C5A, 16'h3C5A);

        // dclock stops after 4 edges
        latch_on(16'h00FF);
        latch_off();
        repeat (4) dclk_pulse();
        t0 = tmo_cnt;
        d0 = done_cnt;
        cyc(150);
`ifdef SNESDEV_TIMEOUT_EN
        check("tmo_pulse", tmo_cnt - t0, 32'd1);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        check("tmo_sdata", {31'd0, sdata}, {31'd0, FB});
`else
        check("tmo_none", tmo_cnt - t0, 32'd0);
        check("tmo_hold_busy", {31'd0, busy}, 32'd1);
`endif
        check("tmo_no_done", done_cnt - d0, 32'd0);
        run_frame("after_stall", 16'h5AA5, 16'h5AA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
